// File: rtl/ct_piu_csr_bridge_mc.sv
// Multi-channel CSR bridge: per-channel request capture, round-robin arbitration
// and a single outstanding register-block transaction with timeout.
module ct_piu_csr_bridge_mc #(
   parameter int unsigned CH_NUM = 4,
   parameter int unsigned OP_W   = 16,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned TO_CYC = 255
) (
   input  logic                              forever_cpuclk,
   input  logic                              cpurst_b,
   input  logic [CH_NUM-1:0]                 ibiu_ciu_csr_sel,
   input  logic [CH_NUM*(OP_W+DATA_W)-1:0]   ibiu_ciu_csr_wdata,
   output logic [CH_NUM-1:0]                 ciu_ibiu_csr_cmplt,
   output logic [CH_NUM*DATA_W-1:0]          ciu_ibiu_csr_rdata,
   output logic [CH_NUM-1:0]                 ciu_ibiu_csr_err,
   output logic                              piu_regs_sel,
   output logic [OP_W-1:0]                   piu_regs_op,
   output logic [DATA_W-1:0]                 piu_regs_wdata,
   input  logic                              regs_piu_cmplt,
   input  logic [DATA_W-1:0]                 regs_piux_rdata,
   output logic                              piu_xx_regs_no_op
);

   localparam int unsigned REQ_W = OP_W + DATA_W;
   localparam int unsigned PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int unsigned CNT_W = $clog2(TO_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYC - 1);
   localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(CH_NUM - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CH_NUM-1:0]   pending;
   logic [CH_NUM-1:0]   pending_nxt;
   logic [REQ_W-1:0]    cap [CH_NUM];
   logic [PTR_W-1:0]    gnt;
   logic [PTR_W-1:0]    gnt_nxt;
   logic [PTR_W-1:0]    idx;
   logic                found;
   logic [CNT_W-1:0]    cnt;
   logic                grant_now;
   logic                wait_done;
   logic                timeout;
   logic                rsp_err;
   logic [DATA_W-1:0]   rsp_data [CH_NUM];

   // gnt doubles as the round-robin pointer: search starts just after it
   always_comb begin
      found   = 1'b0;
      gnt_nxt = gnt;
      idx     = '0;
      for (int unsigned i = 1; i <= CH_NUM; i++) begin
         idx = PTR_W'((32'(gnt) + i) % CH_NUM);
         if (!found && pending[idx]) begin
            found   = 1'b1;
            gnt_nxt = idx;
         end
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      piu_regs_sel = 1'b0;
      grant_now    = 1'b0;
      wait_done    = 1'b0;
      timeout      = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = REQ;
               grant_now = 1'b1;
            end
         end
         REQ: begin
            piu_regs_sel = 1'b1;
            state_nxt    = WAIT;
         end
         WAIT: begin
            if (regs_piu_cmplt) begin
               state_nxt = RESP;
               wait_done = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nxt = RESP;
               wait_done = 1'b1;
               timeout   = 1'b1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // already-pending channels keep their flag and ignore the new pulse
   always_comb begin
      pending_nxt = pending | ibiu_ciu_csr_sel;
      if (grant_now) pending_nxt[gnt_nxt] = 1'b0;
   end

   always_ff @(posedge forever_cpuclk) begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         if (ibiu_ciu_csr_sel[i] && !pending[i])
            cap[i] <= ibiu_ciu_csr_wdata[i*REQ_W +: REQ_W];
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         pending        <= '0;
         gnt            <= PTR_INIT;
         cnt            <= '0;
         piu_regs_op    <= '0;
         piu_regs_wdata <= '0;
         rsp_err        <= 1'b0;
         for (int unsigned i = 0; i < CH_NUM; i++) rsp_data[i] <= '0;
      end else begin
         pending <= pending_nxt;
         if (grant_now) begin
            gnt                           <= gnt_nxt;
            {piu_regs_op, piu_regs_wdata} <= cap[gnt_nxt];
         end
         if (state == WAIT && !wait_done)
            cnt <= (cnt == CNT_LAST) ? cnt : cnt + CNT_W'(1);
         else
            cnt <= '0;
         if (wait_done) begin
            rsp_err       <= timeout;
            rsp_data[gnt] <= timeout ? '1 : regs_piux_rdata;
         end
      end
   end

   always_comb begin
      ciu_ibiu_csr_cmplt = '0;
      ciu_ibiu_csr_err   = '0;
      ciu_ibiu_csr_rdata = '0;
      if (state == RESP) begin
         ciu_ibiu_csr_cmplt[gnt] = 1'b1;
         ciu_ibiu_csr_err[gnt]   = rsp_err;
      end
      for (int unsigned i = 0; i < CH_NUM; i++)
         ciu_ibiu_csr_rdata[i*DATA_W +: DATA_W] = rsp_data[i];
   end

   assign piu_xx_regs_no_op = (state == IDLE) && (pending == '0);

endmodule

// File: tb/tb_ct_piu_csr_bridge_mc.sv
// Bench for ct_piu_csr_bridge_mc: table of arbitration/response vectors checked
// through request/response scoreboards, plus hand-written corner sequences.
module tb_ct_piu_csr_bridge_mc;

   localparam int CH = 4;
   localparam int OW = 16;
   localparam int DW = 64;
   localparam int RW = OW + DW;
   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [CH-1:0]     sel;
   logic [CH*RW-1:0]  wdata_bus;
   logic [CH-1:0]     cmplt;
   logic [CH*DW-1:0]  rdata_bus;
   logic [CH-1:0]     err;
   logic              regs_sel;
   logic [OW-1:0]     regs_op;
   logic [DW-1:0]     regs_wdata;
   logic              resp_cmplt;
   logic              stray_cmplt;
   logic              regs_cmplt;
   logic [DW-1:0]     regs_rdata;
   logic              no_op;

   assign regs_cmplt = resp_cmplt | stray_cmplt;

   ct_piu_csr_bridge_mc #(
      .CH_NUM (CH),
      .OP_W   (OW),
      .DATA_W (DW),
      .TO_CYC (TO)
   ) dut (
      .forever_cpuclk     (clk),
      .cpurst_b           (rst_n),
      .ibiu_ciu_csr_sel   (sel),
      .ibiu_ciu_csr_wdata (wdata_bus),
      .ciu_ibiu_csr_cmplt (cmplt),
      .ciu_ibiu_csr_rdata (rdata_bus),
      .ciu_ibiu_csr_err   (err),
      .piu_regs_sel       (regs_sel),
      .piu_regs_op        (regs_op),
      .piu_regs_wdata     (regs_wdata),
      .regs_piu_cmplt     (regs_cmplt),
      .regs_piux_rdata    (regs_rdata),
      .piu_xx_regs_no_op  (no_op)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          ch;
      logic [15:0] op;
      logic [63:0] wd;
      int          lat;
   } exp_req_t;

   typedef struct {
      int          ch;
      logic [63:0] rd;
      logic        err;
   } exp_rsp_t;

   typedef struct {
      int          delay;
      logic [63:0] rd;
   } resp_t;

   typedef struct {
      logic [3:0]        mask;
      int                n;
      logic [3:0][1:0]   order;
      int                delay;
      logic [3:0][15:0]  op;
      logic [3:0][63:0]  wdata;
      logic [3:0][63:0]  rdata;
   } vec_t;

   exp_req_t req_q[$];
   exp_rsp_t rsp_q[$];
   resp_t    drv_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int nsel = 0;
   int ncmplt = 0;
   int req_cyc = 0;
   int rc_cyc = 0;
   logic [63:0] last_rd [CH];
   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   function automatic vec_t mk(input logic [3:0] mask, input int n, input int o0, input int o1,
                               input int o2, input int o3, input int delay,
                               input logic [15:0] op_base, input logic [63:0] rd_base);
      vec_t v;
      v.mask     = mask;
      v.n        = n;
      v.order[0] = 2'(o0);
      v.order[1] = 2'(o1);
      v.order[2] = 2'(o2);
      v.order[3] = 2'(o3);
      v.delay    = delay;
      for (int c = 0; c < CH; c++) begin
         v.op[c]    = op_base | 16'(c);
         v.wdata[c] = {op_base, 16'(c), 32'h1234_0000 + 32'(c * 7)};
         v.rdata[c] = rd_base + 64'(c * 32'h0101_0101);
      end
      return v;
   endfunction

   // register-block model: replies after the queued delay, or never for delay 0
   initial begin
      resp_t r;
      resp_cmplt = 1'b0;
      regs_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && regs_sel === 1'b1 && drv_q.size() != 0) begin
            r = drv_q.pop_front();
            if (r.delay != 0) begin
               repeat (r.delay) @(posedge clk);
               #1;
               resp_cmplt = 1'b1;
               regs_rdata = r.rd;
               rc_cyc     = cyc;
               @(posedge clk);
               #1;
               resp_cmplt = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin : mon
      exp_req_t er;
      exp_rsp_t es;
      if (rst_n === 1'b1) begin
         if (regs_sel) begin
            nsel++;
            req_cyc = cyc;
            if (req_q.size() == 0) flag("unexpected_regs_sel");
            else begin
               er = req_q.pop_front();
               check("regs_op", 64'(regs_op), 64'(er.op));
               check("regs_wdata", regs_wdata, er.wd);
               if (er.lat >= 0) check("sel_latency", 64'(cyc), 64'(er.lat));
            end
         end
         if (cmplt != '0) begin
            ncmplt++;
            if (rsp_q.size() == 0) flag("unexpected_cmplt");
            else begin
               es = rsp_q.pop_front();
               check("cmplt_vec", 64'(cmplt), 64'(4'b0001 << es.ch));
               check("err_vec", 64'(err), 64'({3'b000, es.err} << es.ch));
               check("rdata", rdata_bus[es.ch*DW +: DW], es.rd);
               check("rsp_latency", 64'(cyc), es.err ? 64'(req_cyc + 1 + TO) : 64'(rc_cyc + 1));
            end
         end
      end
   end

   task automatic wait_idle();
      int k = 0;
      while (no_op !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (no_op !== 1'b1) flag("idle_wait_expired");
   endtask

   task automatic wait_rsp();
      int k = 0;
      while (rsp_q.size() != 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (rsp_q.size() != 0) begin
         flag("rsp_wait_expired");
         rsp_q.delete();
         req_q.delete();
         drv_q.delete();
      end
   endtask

   task automatic apply(input vec_t v);
      int t;
      int ch;
      logic [63:0] rd;
      wait_idle();
      t = cyc;
      for (int k = 0; k < v.n; k++) begin
         ch = int'(v.order[k]);
         rd = (v.delay == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : v.rdata[ch];
         req_q.push_back('{ch: ch, op: v.op[ch], wd: v.wdata[ch], lat: (k == 0) ? t + 2 : -1});
         drv_q.push_back('{delay: v.delay, rd: v.rdata[ch]});
         rsp_q.push_back('{ch: ch, rd: rd, err: (v.delay == 0)});
         last_rd[ch] = rd;
      end
      for (int c = 0; c < CH; c++) wdata_bus[c*RW +: RW] = {v.op[c], v.wdata[c]};
      sel = v.mask;
      @(negedge clk);
      sel = '0;
      wait_rsp();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t;
      int ns0;
      int nc0;
      rst_n       = 1'b0;
      sel         = '0;
      wdata_bus   = '0;
      stray_cmplt = 1'b0;
      for (int c = 0; c < CH; c++) last_rd[c] = '0;

      vecs[0] = mk(4'b1101, 3, 0, 2, 3, 0, 1, 16'hA000, 64'h1111_0000_0000_0000);
      vecs[1] = mk(4'b1001, 2, 0, 3, 0, 0, 2, 16'hB000, 64'h2222_0000_0000_0000);
      vecs[2] = mk(4'b0010, 1, 1, 0, 0, 0, 3, 16'h0000, 64'h0);
      vecs[2].op[1]    = 16'h0010;
      vecs[2].wdata[1] = 64'h0;
      vecs[2].rdata[1] = 64'hDEAD_BEEF;
      vecs[3] = mk(4'b1111, 4, 2, 3, 0, 1, 1, 16'hC000, 64'h3333_0000_0000_0000);
      // reply lands in the same cycle the counter hits its limit
      vecs[4] = mk(4'b0100, 1, 2, 0, 0, 0, TO, 16'hD000, 64'h4444_0000_0000_0000);
      vecs[5] = mk(4'b1000, 1, 3, 0, 0, 0, 0, 16'hE000, 64'h5555_0000_0000_0000);

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_no_op", 64'(no_op), 64'd1);
      check("reset_regs_sel", 64'(regs_sel), 64'd0);
      check("reset_regs_op", 64'(regs_op), 64'd0);
      check("reset_regs_wdata", regs_wdata, 64'd0);
      check("reset_cmplt", 64'(cmplt), 64'd0);
      check("reset_err", 64'(err), 64'd0);
      for (int c = 0; c < CH; c++) check("reset_rdata", rdata_bus[c*DW +: DW], 64'd0);

      for (int v = 0; v < 6; v++) apply(vecs[v]);

      // stray completion after a timeout must be ignored
      wait_idle();
      ns0 = nsel;
      nc0 = ncmplt;
      stray_cmplt = 1'b1;
      @(negedge clk);
      stray_cmplt = 1'b0;
      repeat (8) @(negedge clk);
      check("stray_after_to_sel", 64'(nsel), 64'(ns0));
      check("stray_after_to_cmplt", 64'(ncmplt), 64'(nc0));

      for (int c = 0; c < CH; c++) check("rdata_hold", rdata_bus[c*DW +: DW], last_rd[c]);

      // duplicate sel while pending: second wdata must be dropped
      wait_idle();
      t   = cyc;
      ns0 = nsel;
      nc0 = ncmplt;
      req_q.push_back('{ch: 2, op: 16'h7002, wd: 64'hAAAA_0000_0000_0001, lat: t + 2});
      drv_q.push_back('{delay: 2, rd: 64'h0BAD_F00D});
      rsp_q.push_back('{ch: 2, rd: 64'h0BAD_F00D, err: 1'b0});
      last_rd[2] = 64'h0BAD_F00D;
      wdata_bus[2*RW +: RW] = {16'h7002, 64'hAAAA_0000_0000_0001};
      sel = 4'b0100;
      @(negedge clk);
      wdata_bus[2*RW +: RW] = {16'h7F02, 64'hBBBB_0000_0000_0002};
      @(negedge clk);
      sel = '0;
      wait_rsp();
      repeat (10) @(negedge clk);
      check("dup_sel_count", 64'(nsel - ns0), 64'd1);
      check("dup_cmplt_count", 64'(ncmplt - nc0), 64'd1);

      // reset while waiting: no completion, then a stray reply is ignored
      wait_idle();
      t   = cyc;
      ns0 = nsel;
      nc0 = ncmplt;
      req_q.push_back('{ch: 1, op: 16'h0042, wd: 64'h42, lat: t + 2});
      drv_q.push_back('{delay: 0, rd: 64'h0});
      wdata_bus[1*RW +: RW] = {16'h0042, 64'h42};
      sel = 4'b0010;
      @(negedge clk);
      sel = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_wait_no_op", 64'(no_op), 64'd1);
      check("rst_wait_cmplt", 64'(cmplt), 64'd0);
      check("rst_wait_op", 64'(regs_op), 64'd0);
      for (int c = 0; c < CH; c++) check("rst_wait_rdata", rdata_bus[c*DW +: DW], 64'd0);
      stray_cmplt = 1'b1;
      @(negedge clk);
      stray_cmplt = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_stray_cmplt", 64'(ncmplt), 64'(nc0));
      check("rst_stray_sel", 64'(nsel), 64'(ns0 + 1));
      check("rst_stray_no_op", 64'(no_op), 64'd1);
      check("req_q_drained", 64'(req_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
